image_vector_writer: RTL
========================

IMAGE_VECTOR_WRITER -- requirements
Module: image_vector_writer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 96, image width in pixels.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 96, image height in pixels.
REQ-003 SHALL have parameter PIX_SIZE, default 8, pixel width in bits.
REQ-004 SHALL have parameter LANES, default 8, vector lanes written per store (1..16).
REQ-005 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port Start  input  1  store request; sampled only in IDLE.
REQ-008 SHALL have port Addr  input  16  base pixel address of lane 0.
REQ-009 SHALL have port WD  input  [15:0][15:0]  vector data, 16 lanes of 16 bits; lanes >= LANES ignored.
REQ-010 SHALL have port Busy  output  1  high while a store is in progress (states WRITE and DONE).
REQ-011 SHALL have port Done  output  1  one-cycle pulse at store completion.
REQ-012 SHALL have port Error  output  1  set if any lane address fell out of range; valid with Done.
REQ-013 SHALL have port MemWE  output  1  pixel memory write enable.
REQ-014 SHALL have port MemAddr  output  16  pixel memory address.
REQ-015 SHALL have port MemWD  output  PIX_SIZE  pixel memory write data.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-017 SHALL, in IDLE with Start=1, capture Addr and WD into internal registers, clear lane counter and Error, and go to WRITE.
REQ-018 SHALL ignore Start in WRITE and DONE; captured values stay unchanged.
REQ-019 SHALL, in each WRITE cycle, drive MemAddr = base + lane (16-bit, wraps modulo 2^16) and MemWD = saturated lane data.
REQ-020 SHALL saturate: lane value (unsigned 16-bit) > 2^PIX_SIZE-1 gives all-ones; otherwise low PIX_SIZE bits.
REQ-021 SHALL assert MemWE in a WRITE cycle only if the unwrapped sum base+lane (17-bit) < IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-022 SHALL suppress MemWE and set Error (sticky until next accepted Start) for any out-of-range lane, including a 16-bit wrap.
REQ-023 SHALL increment the lane counter each WRITE cycle; after lane LANES-1 go to DONE.
REQ-024 SHALL, in DONE, pulse Done=1 for exactly one cycle, then return to IDLE.
REQ-025 SHALL have latency: Start accepted at edge N gives lane 0 write at cycle N+1, lane LANES-1 at N+LANES, Done at N+LANES+1.
REQ-026 SHALL accept a new Start no earlier than the first IDLE cycle after Done; back-to-back throughput is one store per LANES+2 cycles.
REQ-027 SHALL drive MemWE=0 in IDLE and DONE; MemAddr and MemWD are don't-care when MemWE=0 but SHALL hold their last value.

Reset
REQ-028 SHALL, while RST=1 at a clock edge, force state IDLE, lane counter 0, Busy=0, Done=0, Error=0, MemWE=0, MemAddr=0, MemWD=0.
REQ-029 SHALL abort a store on reset mid-WRITE; no further MemWE and no Done pulse for the aborted store.
REQ-030 SHALL give RST priority over a simultaneous Start.

Verification
REQ-031 SHALL cover: Addr=0x0100, WD lanes 0..7 = 0x0010..0x0017, Start -> MemWE on 8 consecutive cycles, MemAddr 0x0100..0x0107, MemWD 0x10..0x17, Done at N+9, Error=0.
REQ-032 SHALL cover: lane values 0x00FF, 0x0100, 0xFFFF -> MemWD 0xFF, 0xFF, 0xFF; lane value 0x007F -> 0x7F.
REQ-033 SHALL cover: Addr=9212 (depth 9216) -> lanes 0..3 written to 9212..9215, lanes 4..7 MemWE=0, Error=1 with Done.
REQ-034 SHALL cover: Addr=0xFFFE -> all lanes suppressed (out of range including wrap), Error=1, Done still pulses at N+9.
REQ-035 SHALL cover: Start held high during WRITE and DONE with a changed Addr -> ignored; next store begins the cycle after return to IDLE using the Addr sampled there.
REQ-036 SHALL cover: RST asserted at lane 3 -> MemWE=0 from the next cycle, no Done, Busy=0; a following Start runs a complete, correct store.

Source files
------------

// File: rtl/image_vector_writer.sv
// image_vector_writer: stores one captured vector of up to 16 lanes into a
// pixel memory, one lane per cycle, saturating each lane to PIX_SIZE bits
// and suppressing writes whose address falls outside the image.
module image_vector_writer #(
    parameter int unsigned IMAGE_WIDTH  = 96,
    parameter int unsigned IMAGE_HEIGHT = 96,
    parameter int unsigned PIX_SIZE     = 8,
    parameter int unsigned LANES        = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [15:0]           Addr,
    input  logic [15:0][15:0]     WD,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic                  MemWE,
    output logic [15:0]           MemAddr,
    output logic [PIX_SIZE-1:0]   MemWD
);

    localparam int unsigned DEPTH     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [3:0]  LAST_LANE = 4'(LANES - 1);
    localparam logic [16:0] PIX_MAX   = 17'((32'd1 << PIX_SIZE) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_lane;
    logic [15:0]           r_base;
    logic [15:0][15:0]     r_wd;

    logic [16:0]           w_sum;
    logic                  w_in_range;
    logic [15:0]           w_lane_data;
    logic [PIX_SIZE-1:0]   w_sat;

    // Unwrapped lane address, range check and saturated lane data
    always_comb begin
        w_sum       = {1'b0, r_base} + {13'd0, r_lane};
        w_in_range  = (32'(w_sum) < DEPTH);
        w_lane_data = r_wd[r_lane];
        if ({1'b0, w_lane_data} > PIX_MAX) begin
            w_sat = '1;
        end else begin
            w_sat = w_lane_data[PIX_SIZE-1:0];
        end
    end

    // Store sequencer with registered memory and status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_lane  <= 4'd0;
            r_base  <= 16'd0;
            r_wd    <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
            MemWE   <= 1'b0;
            MemAddr <= 16'd0;
            MemWD   <= '0;
        end else begin
            Done  <= 1'b0;
            MemWE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_base  <= Addr;
                        r_wd    <= WD;
                        r_lane  <= 4'd0;
                        Error   <= 1'b0;
                        Busy    <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    MemAddr <= w_sum[15:0];
                    MemWD   <= w_sat;
                    MemWE   <= w_in_range;
                    if (!w_in_range) begin
                        Error <= 1'b1;
                    end
                    if (r_lane == LAST_LANE) begin
                        r_lane  <= 4'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_lane <= r_lane + 4'd1;
                    end
                end
                S_DONE: begin
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
